tdc_csr_loader: RTL

Serial configuration writer for the TDC wrapper control CSR. It deserialises framed, parity-checked configuration words from the pin interface and validates header, parity and encoding. It commits `ctl_pls_src`, `ctl_tog` and `ctl_delay_line` (the `tdc_wrapper_pkg` enums) to the wrapper, but only while the TDC is idle. It sits between the user I/O pins and the wrapper control inputs, as the write side of the control CSR.

---
 rtl/tdc_csr_loader.sv | 186 ++++++++++++++++++
 1 files changed

// File: rtl/tdc_csr_loader.sv
// Serial write port for the TDC wrapper control CSR: framed, parity-checked, committed only while the TDC is idle.
// Optional macro TDC_CSR_READBACK_EN shifts the committed CSR out on cfg_sdo during a frame.
package tdc_wrapper_pkg;
  typedef enum logic { PG_IN = 1'b0, PG_TOG = 1'b1 } ctrl_pulse_src_t;
  typedef enum logic { TOG_BYP = 1'b0, TOG_REG = 1'b1 } ctrl_tog_t;
  typedef enum logic [1:0] { MUX = 2'd0, ADD = 2'd1 } ctrl_delay_line_t;
endpackage

module tdc_csr_loader
  import tdc_wrapper_pkg::*;
#(
  parameter int               HDR_W = 4,
  parameter logic [HDR_W-1:0] HDR   = 4'hA
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             cfg_sel,
  input  logic             cfg_vld,
  input  logic             cfg_sdi,
  input  logic             tdc_busy,
  output ctrl_pulse_src_t  ctl_pls_src,
  output ctrl_tog_t        ctl_tog,
  output ctrl_delay_line_t ctl_delay_line,
  output logic             csr_upd,
  output logic             cfg_err,
  output logic [1:0]       err_code,
  output logic             busy,
  output logic             cfg_sdo
);

  localparam int FRAME_W = HDR_W + 5;

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_SHIFT = 3'd1;
  localparam logic [2:0] S_CHECK = 3'd2;
  localparam logic [2:0] S_PEND  = 3'd3;
  localparam logic [2:0] S_DRAIN = 3'd4;

  logic [2:0]         state_q, state_d;
  logic [FRAME_W-1:0] sr_q, sr_d;
  logic [3:0]         cnt_q, cnt_d;
  ctrl_pulse_src_t    pls_q, pls_d;
  ctrl_tog_t          tog_q, tog_d;
  ctrl_delay_line_t   dl_q, dl_d;
  logic               upd_q, upd_d;
  logic               err_q, err_d;
  logic [1:0]         code_q, code_d;
  logic               commit;

  logic [FRAME_W-1:0] sr_shift;
  logic               hdr_ok, par_ok, enc_ok;

  assign sr_shift = {sr_q[FRAME_W-2:0], cfg_sdi};
  assign hdr_ok   = (sr_q[FRAME_W-1 -: HDR_W] == HDR);
  assign par_ok   = ~(^sr_q);
  // Delay-line codes 2 and 3 are reserved; only the MSB of the field needs checking.
  assign enc_ok   = ~sr_q[2];

  always_comb begin
    state_d = state_q;
    sr_d    = sr_q;
    cnt_d   = cnt_q;
    pls_d   = pls_q;
    tog_d   = tog_q;
    dl_d    = dl_q;
    code_d  = code_q;
    upd_d   = 1'b0;
    err_d   = 1'b0;
    commit  = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (cfg_sel) begin
          state_d = S_SHIFT;
          if (cfg_vld) begin
            sr_d  = sr_shift;
            cnt_d = 4'd1;
          end
        end
      end
      S_SHIFT: begin
        if (!cfg_sel) begin
          state_d = S_IDLE;
          sr_d    = '0;
          cnt_d   = '0;
        end else if (cfg_vld) begin
          sr_d  = sr_shift;
          cnt_d = cnt_q + 4'd1;
          if (cnt_q == 4'(FRAME_W - 1)) state_d = S_CHECK;
        end
      end
      S_CHECK: begin
        cnt_d = '0;
        if (!hdr_ok || !par_ok || !enc_ok) begin
          err_d   = 1'b1;
          code_d  = !hdr_ok ? 2'd1 : (!par_ok ? 2'd2 : 2'd3);
          state_d = S_DRAIN;
        end else if (!tdc_busy) begin
          commit  = 1'b1;
          state_d = S_DRAIN;
        end else begin
          state_d = S_PEND;
        end
      end
      S_PEND: begin
        if (!tdc_busy) begin
          commit  = 1'b1;
          state_d = S_DRAIN;
        end
      end
      S_DRAIN: begin
        if (!cfg_sel) begin
          state_d = S_IDLE;
          sr_d    = '0;
        end
      end
      default: state_d = S_IDLE;
    endcase
    if (commit) begin
      pls_d  = ctrl_pulse_src_t'(sr_q[4]);
      tog_d  = ctrl_tog_t'(sr_q[3]);
      dl_d   = ctrl_delay_line_t'(sr_q[2:1]);
      code_d = 2'd0;
      upd_d  = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      sr_q    <= '0;
      cnt_q   <= '0;
      pls_q   <= PG_IN;
      tog_q   <= TOG_BYP;
      dl_q    <= MUX;
      upd_q   <= 1'b0;
      err_q   <= 1'b0;
      code_q  <= 2'd0;
    end else begin
      state_q <= state_d;
      sr_q    <= sr_d;
      cnt_q   <= cnt_d;
      pls_q   <= pls_d;
      tog_q   <= tog_d;
      dl_q    <= dl_d;
      upd_q   <= upd_d;
      err_q   <= err_d;
      code_q  <= code_d;
    end
  end

`ifdef TDC_CSR_READBACK_EN
  logic [FRAME_W-1:0] snap_q, snap_d, snap_now;
  logic [FRAME_W-2:0] snap_body;

  assign snap_body = {HDR, pls_q, tog_q, dl_q};
  assign snap_now  = {snap_body, ^snap_body};

  // A first bit taken in the IDLE cycle already consumes the snapshot MSB, so load it pre-shifted.
  always_comb begin
    snap_d = snap_q;
    if (state_q == S_IDLE && cfg_sel)
      snap_d = cfg_vld ? {snap_now[FRAME_W-2:0], 1'b0} : snap_now;
    else if (state_q == S_SHIFT && cfg_sel && cfg_vld)
      snap_d = {snap_q[FRAME_W-2:0], 1'b0};
  end

  always_ff @(posedge clk) begin
    if (rst) snap_q <= '0;
    else     snap_q <= snap_d;
  end

  assign cfg_sdo = (state_q == S_SHIFT) ? snap_q[FRAME_W-1] :
                   ((state_q == S_IDLE && cfg_sel) ? snap_now[FRAME_W-1] : 1'b0);
`else
  assign cfg_sdo = 1'b0;
`endif

  assign ctl_pls_src    = pls_q;
  assign ctl_tog        = tog_q;
  assign ctl_delay_line = dl_q;
  assign csr_upd        = upd_q;
  assign cfg_err        = err_q;
  assign err_code       = code_q;
  assign busy           = (state_q != S_IDLE);

endmodule
